// File: rtl/vga_arb_pkg.sv
// Shared types and default geometry for the VGA VRAM arbiter slice.
package vga_arb_pkg;

   localparam int unsigned VRAM_AW = 13;
   localparam int unsigned VRAM_DW = 8;

   typedef enum logic [1:0] {
      GNT_NONE = 2'd0,
      GNT_DISP = 2'd1,
      GNT_WR   = 2'd2
   } gnt_t;

   typedef struct packed {
      logic [VRAM_AW-1:0] addr;
      logic [VRAM_DW-1:0] data;
   } vram_wr_t;

endpackage

// File: rtl/vga_wr_fifo.sv
// Host write FIFO for the VRAM arbiter; power-of-2 depth, extra pointer MSB
// distinguishes full from empty. Push is ignored when full, pop when empty.
module vga_wr_fifo #(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned W     = 21
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [W-1:0]             din,
   input  logic                     pop,
   output logic [W-1:0]             dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int unsigned PW = $clog2(DEPTH);

   logic [PW:0]  wr_ptr;
   logic [PW:0]  rd_ptr;
   logic [W-1:0] mem [DEPTH];
   logic         do_push;
   logic         do_pop;

   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[PW-1:0]] <= din;
   end

   assign dout  = mem[rd_ptr[PW-1:0]];
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
   assign level = wr_ptr - rd_ptr;

endmodule

// File: rtl/vga_vram_arbiter.sv
// Single-port VRAM arbiter: display reads always win, buffered host writes
// drain on idle (blanking) cycles. Define VGA_ARB_STATS_EN for stall/drain counters.
module vga_vram_arbiter
   import vga_arb_pkg::*;
#(
   parameter int unsigned AW         = VRAM_AW,
   parameter int unsigned DW         = VRAM_DW,
   parameter int unsigned FIFO_DEPTH = 8
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          disp_req,
   input  logic [AW-1:0]                 disp_addr,
   output logic [DW-1:0]                 disp_rdata,
   output logic                          disp_rvalid,
   input  logic                          wr_valid,
   output logic                          wr_ready,
   input  logic [AW-1:0]                 wr_addr,
   input  logic [DW-1:0]                 wr_data,
   output logic [AW-1:0]                 ram_addr,
   output logic [DW-1:0]                 ram_wdata,
   output logic                          ram_we,
   input  logic [DW-1:0]                 ram_rdata,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
`ifdef VGA_ARB_STATS_EN
   ,
   output logic [15:0]                   stall_cnt,
   output logic [15:0]                   drain_cnt
`endif
);

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } wr_entry_t;

   gnt_t          gnt_d;
   gnt_t          gnt_q;
   wr_entry_t     wr_in;
   wr_entry_t     head;
   logic          fifo_full;
   logic          fifo_empty;
   logic          fifo_pop;
   logic [AW-1:0] addr_q;
   logic [DW-1:0] wdata_q;

   assign wr_in    = '{addr: wr_addr, data: wr_data};
   assign wr_ready = !fifo_full;

   vga_wr_fifo #(
      .DEPTH (FIFO_DEPTH),
      .W     (AW + DW)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (wr_valid && wr_ready),
      .din   (wr_in),
      .pop   (fifo_pop),
      .dout  (head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .level (fifo_level)
   );

   // RAM port follows the grant combinationally; idle cycles replay the last address/data
   always_comb begin
      gnt_d     = GNT_NONE;
      ram_addr  = addr_q;
      ram_wdata = wdata_q;
      ram_we    = 1'b0;
      fifo_pop  = 1'b0;
      if (disp_req) begin
         gnt_d    = GNT_DISP;
         ram_addr = disp_addr;
      end else if (!fifo_empty) begin
         gnt_d     = GNT_WR;
         ram_addr  = head.addr;
         ram_wdata = head.data;
         ram_we    = 1'b1;
         fifo_pop  = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         gnt_q   <= GNT_NONE;
         addr_q  <= '0;
         wdata_q <= '0;
      end else begin
         gnt_q   <= gnt_d;
         addr_q  <= ram_addr;
         wdata_q <= ram_wdata;
      end
   end

   // The RAM has one cycle of read latency, so last cycle's display grant marks valid data now
   assign disp_rvalid = (gnt_q == GNT_DISP);
   assign disp_rdata  = ram_rdata;

`ifdef VGA_ARB_STATS_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_cnt <= '0;
         drain_cnt <= '0;
      end else begin
         if (wr_valid && !wr_ready && (stall_cnt != '1)) stall_cnt <= stall_cnt + 16'd1;
         if ((gnt_d == GNT_WR) && (drain_cnt != '1))     drain_cnt <= drain_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_vga_vram_arbiter.sv
// Directed self-checking bench for vga_vram_arbiter with a behavioural VRAM model.
module tb_vga_vram_arbiter;

   localparam int unsigned AW = 13;
   localparam int unsigned DW = 8;
   localparam int unsigned FD = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          disp_req = 1'b0;
   logic [AW-1:0] disp_addr = '0;
   logic [DW-1:0] disp_rdata;
   logic          disp_rvalid;
   logic          wr_valid = 1'b0;
   logic          wr_ready;
   logic [AW-1:0] wr_addr = '0;
   logic [DW-1:0] wr_data = '0;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_wdata;
   logic          ram_we;
   logic [DW-1:0] ram_rdata;
   logic [3:0]    fifo_level;
`ifdef VGA_ARB_STATS_EN
   logic [15:0]   stall_cnt;
   logic [15:0]   drain_cnt;
`endif

   int checks = 0;
   int errors = 0;

   logic [DW-1:0] vram [0:(1<<AW)-1] = '{default: 8'h00};

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (ram_we) vram[ram_addr] <= ram_wdata;
      ram_rdata <= vram[ram_addr];
   end

   vga_vram_arbiter #(
      .AW         (AW),
      .DW         (DW),
      .FIFO_DEPTH (FD)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .disp_req    (disp_req),
      .disp_addr   (disp_addr),
      .disp_rdata  (disp_rdata),
      .disp_rvalid (disp_rvalid),
      .wr_valid    (wr_valid),
      .wr_ready    (wr_ready),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .ram_addr    (ram_addr),
      .ram_wdata   (ram_wdata),
      .ram_we      (ram_we),
      .ram_rdata   (ram_rdata),
      .fifo_level  (fifo_level)
`ifdef VGA_ARB_STATS_EN
      ,
      .stall_cnt   (stall_cnt),
      .drain_cnt   (drain_cnt)
`endif
   );

   task automatic test_reset;
      rst = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk); #2;
         checks++;
         if (fifo_level !== 4'd0 || wr_ready !== 1'b1 || ram_we !== 1'b0 || disp_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle cyc %0d: level=%0d ready=%b we=%b rvalid=%b, want 0/1/0/0",
                     i, fifo_level, wr_ready, ram_we, disp_rvalid);
         end
      end
      checks++;
      if (ram_addr !== 13'd0 || ram_wdata !== 8'h00) begin
         errors++;
         $display("FAIL reset_ram_port: addr=%0d wdata=%h, want 0/00", ram_addr, ram_wdata);
      end
   endtask

   task automatic test_read;
      @(negedge clk);
      wr_valid = 1'b1; wr_addr = 13'd100; wr_data = 8'h41;
      #2;
      checks++;
      if (ram_we !== 1'b0 || wr_ready !== 1'b1) begin
         errors++;
         $display("FAIL push_no_bypass: we=%b ready=%b, want 0/1", ram_we, wr_ready);
      end
      @(negedge clk);
      wr_valid = 1'b0;
      #2;
      checks++;
      if (ram_we !== 1'b1 || ram_addr !== 13'd100 || ram_wdata !== 8'h41) begin
         errors++;
         $display("FAIL preload_write: we=%b addr=%0d data=%h, want 1/100/41", ram_we, ram_addr, ram_wdata);
      end
      @(negedge clk); #2;
      checks++;
      if (ram_we !== 1'b0 || fifo_level !== 4'd0) begin
         errors++;
         $display("FAIL preload_done: we=%b level=%0d, want 0/0", ram_we, fifo_level);
      end
      @(negedge clk);
      disp_req = 1'b1; disp_addr = 13'd100;
      #2;
      checks++;
      if (disp_rvalid !== 1'b0 || ram_we !== 1'b0 || ram_addr !== 13'd100) begin
         errors++;
         $display("FAIL read_issue: rvalid=%b we=%b addr=%0d, want 0/0/100", disp_rvalid, ram_we, ram_addr);
      end
      @(negedge clk);
      disp_req = 1'b0;
      #2;
      checks++;
      if (disp_rvalid !== 1'b1 || disp_rdata !== 8'h41) begin
         errors++;
         $display("FAIL read_data: rvalid=%b rdata=%h, want 1/41", disp_rvalid, disp_rdata);
      end
      @(negedge clk); #2;
      checks++;
      if (disp_rvalid !== 1'b0) begin
         errors++;
         $display("FAIL read_single: rvalid=%b, want 0", disp_rvalid);
      end
   endtask

   task automatic test_fill_full;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         disp_req = 1'b1; disp_addr = 13'd200;
         wr_valid = 1'b1; wr_addr = AW'(i); wr_data = 8'(8'h10 + i);
         #2;
         checks++;
         if (ram_we !== 1'b0 || wr_ready !== 1'b1 || fifo_level !== 4'(i)) begin
            errors++;
            $display("FAIL fill_push %0d: we=%b ready=%b level=%0d, want 0/1/%0d",
                     i, ram_we, wr_ready, fifo_level, i);
         end
      end
      for (int j = 0; j < 5; j++) begin
         @(negedge clk);
         if (j == 0) begin
            wr_addr = 13'd8; wr_data = 8'h18;
         end
         #2;
         checks++;
         if (wr_ready !== 1'b0 || fifo_level !== 4'd8 || ram_we !== 1'b0) begin
            errors++;
            $display("FAIL fill_full %0d: ready=%b level=%0d we=%b, want 0/8/0",
                     j, wr_ready, fifo_level, ram_we);
         end
      end
      @(negedge clk);
      wr_valid = 1'b0;
      #2;
`ifdef VGA_ARB_STATS_EN
      checks++;
      if (stall_cnt !== 16'd5) begin
         errors++;
         $display("FAIL stall_cnt: got %0d, want 5", stall_cnt);
      end
`endif
      checks++;
      if (fifo_level !== 4'd8) begin
         errors++;
         $display("FAIL fill_hold: level=%0d, want 8", fifo_level);
      end
   endtask

   task automatic test_drain;
      int pulses;
      pulses = 0;
      @(negedge clk);
      disp_req = 1'b0;
      for (int c = 0; c < 160; c++) begin
         #2;
         if (ram_we === 1'b1) begin
            checks++;
            if (c != pulses || ram_addr !== AW'(pulses) || ram_wdata !== 8'(8'h10 + pulses)) begin
               errors++;
               $display("FAIL drain_order: cyc %0d addr=%0d data=%h, want cyc %0d addr=%0d data=%h",
                        c, ram_addr, ram_wdata, pulses, pulses, 8'(8'h10 + pulses));
            end
            pulses++;
         end
         @(negedge clk);
      end
      #2;
      checks++;
      if (pulses != 8 || fifo_level !== 4'd0 || wr_ready !== 1'b1) begin
         errors++;
         $display("FAIL drain_done: pulses=%0d level=%0d ready=%b, want 8/0/1", pulses, fifo_level, wr_ready);
      end
      for (int k = 0; k < 8; k++) begin
         checks++;
         if (vram[k] !== 8'(8'h10 + k)) begin
            errors++;
            $display("FAIL drain_mem[%0d]: got %h, want %h", k, vram[k], 8'(8'h10 + k));
         end
      end
`ifdef VGA_ARB_STATS_EN
      checks++;
      if (drain_cnt !== 16'd9) begin
         errors++;
         $display("FAIL drain_cnt: got %0d, want 9", drain_cnt);
      end
`endif
   endtask

   task automatic test_push_pop;
      logic [7:0] exp_d [4];
      exp_d[0] = 8'hA0; exp_d[1] = 8'hA1; exp_d[2] = 8'hA2; exp_d[3] = 8'hA3;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         disp_req = 1'b1; disp_addr = 13'd300;
         wr_valid = 1'b1; wr_addr = AW'(20 + i); wr_data = exp_d[i];
      end
      @(negedge clk);
      wr_valid = 1'b0;
      #2;
      checks++;
      if (fifo_level !== 4'd3) begin
         errors++;
         $display("FAIL pp_level_pre: level=%0d, want 3", fifo_level);
      end
      @(negedge clk);
      disp_req = 1'b0;
      wr_valid = 1'b1; wr_addr = 13'd23; wr_data = exp_d[3];
      #2;
      checks++;
      if (ram_we !== 1'b1 || ram_addr !== 13'd20 || ram_wdata !== 8'hA0 || wr_ready !== 1'b1) begin
         errors++;
         $display("FAIL pp_same_cycle: we=%b addr=%0d data=%h ready=%b, want 1/20/a0/1",
                  ram_we, ram_addr, ram_wdata, wr_ready);
      end
      @(negedge clk);
      disp_req = 1'b1; wr_valid = 1'b0;
      #2;
      checks++;
      if (fifo_level !== 4'd3) begin
         errors++;
         $display("FAIL pp_level_post: level=%0d, want 3", fifo_level);
      end
      @(negedge clk);
      disp_req = 1'b0;
      repeat (5) @(negedge clk);
      #2;
      checks++;
      if (fifo_level !== 4'd0) begin
         errors++;
         $display("FAIL pp_drained: level=%0d, want 0", fifo_level);
      end
      // Back-to-back readback of 20..23 with no idle cycle between requests
      @(negedge clk);
      disp_req = 1'b1; disp_addr = 13'd20;
      for (int i = 1; i <= 4; i++) begin
         @(negedge clk);
         if (i < 4) disp_addr = AW'(20 + i);
         else       disp_req  = 1'b0;
         #2;
         checks++;
         if (disp_rvalid !== 1'b1 || disp_rdata !== exp_d[i-1]) begin
            errors++;
            $display("FAIL pp_readback %0d: rvalid=%b rdata=%h, want 1/%h",
                     19 + i, disp_rvalid, disp_rdata, exp_d[i-1]);
         end
      end
      @(negedge clk); #2;
      checks++;
      if (disp_rvalid !== 1'b0) begin
         errors++;
         $display("FAIL pp_rvalid_end: rvalid=%b, want 0", disp_rvalid);
      end
   endtask

   task automatic test_reset_mid_drain;
      int stray;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         disp_req = 1'b1; disp_addr = 13'd400;
         wr_valid = 1'b1; wr_addr = AW'(40 + i); wr_data = 8'(8'hC0 + i);
      end
      @(negedge clk);
      wr_valid = 1'b0;
      #2;
      checks++;
      if (fifo_level !== 4'd5) begin
         errors++;
         $display("FAIL rst_level_pre: level=%0d, want 5", fifo_level);
      end
      @(negedge clk);
      disp_req = 1'b0;
      #2;
      checks++;
      if (ram_we !== 1'b1 || ram_addr !== 13'd40) begin
         errors++;
         $display("FAIL rst_first_drain: we=%b addr=%0d, want 1/40", ram_we, ram_addr);
      end
      @(negedge clk); #2;
      checks++;
      if (ram_we !== 1'b1 || ram_addr !== 13'd41 || fifo_level !== 4'd4) begin
         errors++;
         $display("FAIL rst_second_drain: we=%b addr=%0d level=%0d, want 1/41/4", ram_we, ram_addr, fifo_level);
      end
      #1 rst = 1'b0;
      #1;
      checks++;
      if (ram_we !== 1'b0 || fifo_level !== 4'd0 || wr_ready !== 1'b1 || disp_rvalid !== 1'b0) begin
         errors++;
         $display("FAIL rst_async: we=%b level=%0d ready=%b rvalid=%b, want 0/0/1/0",
                  ram_we, fifo_level, wr_ready, disp_rvalid);
      end
      @(negedge clk);
      rst = 1'b1;
      stray = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk); #2;
         if (ram_we !== 1'b0) stray++;
      end
      checks++;
      if (stray != 0) begin
         errors++;
         $display("FAIL rst_no_retry: stray write cycles=%0d, want 0", stray);
      end
      checks++;
      if (vram[40] !== 8'hC0 || vram[41] !== 8'h00 || vram[42] !== 8'h00 ||
          vram[43] !== 8'h00 || vram[44] !== 8'h00) begin
         errors++;
         $display("FAIL rst_mem: 40..44=%h %h %h %h %h, want c0 00 00 00 00",
                  vram[40], vram[41], vram[42], vram[43], vram[44]);
      end
   endtask

   initial begin
      test_reset;
      test_read;
      test_fill_full;
      test_drain;
      test_push_pop;
      test_reset_mid_drain;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule

// File: doc/vga_vram_arbiter.md
Name: vga_vram_arbiter

Overview:
- Shares one single-port video RAM (character/pixel memory) between the display fetch path and a host writer.
- Display fetch is driven from vgaController x/y through videoGen address logic.
- The host writer (processor/loader) pushes writes through a valid/ready port into an internal FIFO.
- Display reads have absolute priority; buffered writes drain only on cycles with no display request, i.e. blanking.
- Sits in the vgaclk domain, between the timing/video generation logic and the VRAM macro.

Parameters:
- AW, 13, VRAM address width (80x60 character grid = 4800 cells).
- DW, 8, VRAM data width.
- FIFO_DEPTH, 8, write FIFO entries; power of 2, minimum 2.

Ports:
- clk  in  1  pixel clock (vgaclk domain).
- rst  in  1  asynchronous, active-low reset.
- disp_req  in  1  display read request this cycle.
- disp_addr  in  AW  display read address.
- disp_rdata  out  DW  read data.
- disp_rvalid  out  1  disp_rdata valid.
- wr_valid  in  1  host write offer.
- wr_ready  out  1  FIFO can accept.
- wr_addr  in  AW  host write address.
- wr_data  in  DW  host write data.
- ram_addr  out  AW  VRAM address.
- ram_wdata  out  DW  VRAM write data.
- ram_we  out  1  VRAM write enable.
- ram_rdata  in  DW  VRAM read data; synchronous read, 1-cycle latency.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (rst=0, asynchronous):
  - FIFO emptied; fifo_level=0; wr_ready=1.
  - disp_rvalid=0; ram_we=0; ram_addr=0; ram_wdata=0.
  - Grant register = GNT_NONE.
- Reset mid-operation: buffered writes are discarded, not retried. An in-flight read produces no disp_rvalid.
- Per-cycle grant (combinational decision, registered copy gnt_q):
  - disp_req=1 -> GNT_DISP: ram_addr=disp_addr, ram_we=0.
  - else FIFO non-empty -> GNT_WR: ram_addr/ram_wdata = FIFO head, ram_we=1, head popped at clock edge.
  - else GNT_NONE: ram_we=0, ram_addr holds its last value.
- Read latency: disp_req at edge N -> disp_rvalid=1 during cycle N+1, with disp_rdata=ram_rdata (pass-through). disp_rvalid is the registered disp_req.
- Back-to-back disp_req yields one rvalid per cycle. No bubbles are inserted.
- Host handshake:
  - Transfer occurs when wr_valid & wr_ready at the edge.
  - wr_ready = (fifo_level < FIFO_DEPTH), based on the current registered level. No same-cycle bypass when full, even if a pop occurs.
  - wr_valid must hold with stable addr/data until accepted.
- Simultaneous push and pop (not full): level unchanged; FIFO order preserved.
- Push when empty: the entry is written to RAM no earlier than the next cycle (no FIFO bypass).
- Full FIFO with continuous disp_req: wr_ready stays 0 indefinitely. The display is never stalled.
- Wrap-around: read/write pointers are $clog2(FIFO_DEPTH)+1 bits; full = MSBs differ and LSBs equal.
- Write ordering: writes reach RAM in acceptance order. A display read of an address with a buffered write returns the old data (accepted tearing).
- Grant states: GNT_NONE, GNT_DISP, GNT_WR. Any state transitions to any other each cycle per the priority rule above.

Optional Feature:
- VGA_ARB_STATS_EN defined adds outputs stall_cnt[15:0] and drain_cnt[15:0]:
  - stall_cnt counts cycles with wr_valid & !wr_ready.
  - drain_cnt counts GNT_WR cycles.
  - Both saturate at 16'hFFFF; both cleared by rst.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package vga_arb_pkg:
  - VRAM_AW=13, VRAM_DW=8.
  - typedef enum logic [1:0] gnt_t {GNT_NONE, GNT_DISP, GNT_WR}.
  - typedef struct packed {addr, data} vram_wr_t.
- Sub-module vga_wr_fifo:
  - Parameterised depth.
  - Ports: push/pop/full/empty/level.
  - Same clk/rst convention.

Test Plan:
- Reset then idle 10 cycles -> fifo_level=0, wr_ready=1, ram_we=0, disp_rvalid=0 throughout.
- Preload RAM[100]=8'h41; disp_req=1, disp_addr=100 at edge N -> disp_rvalid=1, disp_rdata=8'h41 at N+1 only.
- disp_req held 1; push 8 writes -> fifo_level=8, wr_ready=0, ram_we never 1. A 9th wr_valid is held; stall_cnt increments if the feature is enabled.
- Drop disp_req for 160 cycles with 8 queued writes (addr 0..7, data 8'h10..8'h17) -> 8 consecutive ram_we pulses in order, then level=0 and wr_ready=1.
- Push and pop in the same cycle at level 3 -> level stays 3; data order verified by readback.
- Assert rst mid-drain with level 5 -> ram_we=0 immediately, level=0; the remaining writes never appear on the RAM port.
